// File: rtl/if_id_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
package if_id_pkg;

   localparam logic [31:0] IF_ID_NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam int unsigned DEF_XLEN = 32;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] inst;
      logic                is_ctrl;
   } if_id_entry_t;

   function automatic logic is_ctrl_op(input logic [6:0] opcode);
      return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH-entry register array for queued instructions: one write port, one
// combinational read port.
module if_id_fifo_mem #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 1,
   parameter type         entry_t = if_id_pkg::if_id_entry_t
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  entry_t            wdata,
   input  logic [ADDR_W-1:0] raddr,
   output entry_t            rdata
);

   entry_t mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; count in the parent decides what is valid.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: issues PC requests to a 1-cycle instruction memory and
// buffers {pc, inst} in a DEPTH-entry FIFO. Define IF_ID_PREDECODE_EN to store a control-flow flag per entry.
module if_id_queue
   import if_id_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 2,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(IF_ID_NOP)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic [XLEN-1:0] req_pc,
   output logic            req_ready,
   output logic [XLEN-3:0] mem_addr,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst,
   output logic            id_is_ctrl
);

   localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     CNT_W     = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

`ifdef IF_ID_PREDECODE_EN
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            is_ctrl;
   } entry_t;
`else
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } entry_t;
`endif

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             inflight_q, inflight_d;
   logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;

   logic             req_fire;
   logic             pop;
   logic             push;
   logic [CNT_W:0]   occupancy;
   entry_t           wr_entry;
   entry_t           rd_entry;
   logic [1:0]       unused_pc_lsb;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   assign mem_addr      = req_pc[XLEN-1:2];
   assign unused_pc_lsb = req_pc[1:0];

   assign id_valid  = (count_q != '0);
   assign pop       = id_valid & id_ready;
   assign push      = inflight_q & ~flush;
   // The in-flight response already owns a slot, so occupancy counts it.
   assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign req_ready = rst_n & ~flush & ((occupancy < DEPTH_OCC) | pop);
   assign req_fire  = req_valid & req_ready;

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      inflight_d    = req_fire;
      inflight_pc_d = req_fire ? req_pc : inflight_pc_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_next(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.pc   = inflight_pc_q;
      wr_entry.inst = mem_rdata;
`ifdef IF_ID_PREDECODE_EN
      wr_entry.is_ctrl = is_ctrl_op(mem_rdata[6:0]);
`endif
   end

   if_id_fifo_mem #(
      .DEPTH   (DEPTH),
      .ADDR_W  (PTR_W),
      .entry_t (entry_t)
   ) u_fifo_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign id_pc   = id_valid ? rd_entry.pc   : '0;
   assign id_inst = id_valid ? rd_entry.inst : NOP_INST;
`ifdef IF_ID_PREDECODE_EN
   assign id_is_ctrl = id_valid & rd_entry.is_ctrl;
`else
   assign id_is_ctrl = 1'b0;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a DEPTH=2 instance for most scenarios and a
// DEPTH=3 instance for sustained push/pop with pointer wrap.
module tb_if_id_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PREDECODE_EN
   localparam logic EXP_CTRL = 1'b1;
`else
   localparam logic EXP_CTRL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, flush, id_valid, id_ready, id_is_ctrl;
   logic [31:0] req_pc, mem_rdata, id_pc, id_inst;
   logic [29:0] mem_addr;

   logic        req_valid_3, req_ready_3, flush_3, id_valid_3, id_ready_3, id_is_ctrl_3;
   logic [31:0] req_pc_3, mem_rdata_3, id_pc_3, id_inst_3;
   logic [29:0] mem_addr_3;

   int n_checks = 0;
   int n_errors = 0;

   if_id_queue #(.XLEN(32), .DEPTH(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_pc     (req_pc),
      .req_ready  (req_ready),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_is_ctrl (id_is_ctrl)
   );

   if_id_queue #(.XLEN(32), .DEPTH(3)) u_dut3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_3),
      .req_pc     (req_pc_3),
      .req_ready  (req_ready_3),
      .mem_addr   (mem_addr_3),
      .mem_rdata  (mem_rdata_3),
      .flush      (flush_3),
      .id_valid   (id_valid_3),
      .id_ready   (id_ready_3),
      .id_pc      (id_pc_3),
      .id_inst    (id_inst_3),
      .id_is_ctrl (id_is_ctrl_3)
   );

   // Instruction memory model: fixed content, one-cycle read latency.
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      if (pc == 32'h400) return 32'h0000_006F;
      if (pc == 32'h404) return 32'h0000_0013;
      return {pc[23:0], 8'h13};
   endfunction

   always @(posedge clk) begin
      mem_rdata   <= inst_of({mem_addr, 2'b00});
      mem_rdata_3 <= inst_of({mem_addr_3, 2'b00});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      int fires, pops, tail_pops;
      logic [31:0] next_pc, exp_pc;

      rst_n = 1'b0;
      req_valid = 1'b0; req_pc = '0; flush = 1'b0; id_ready = 1'b0;
      req_valid_3 = 1'b0; req_pc_3 = '0; flush_3 = 1'b0; id_ready_3 = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", id_valid, 0);
      check("rst_inst", id_inst, NOP);
      check("rst_pc", id_pc, 0);
      check("rst_ctrl", id_is_ctrl, 0);
      check("rst_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming: three back-to-back requests, 2-cycle latency, one per cycle out
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = (c < 3); req_pc = 32'(c * 4); id_ready = 1'b1;
         #1;
         if (c < 3) check("t1_ready", req_ready, 1);
         check("t1_valid", id_valid, (c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) begin
            check("t1_pc", id_pc, 32'((c - 2) * 4));
            check("t1_inst", id_inst, inst_of(32'((c - 2) * 4)));
         end else begin
            check("t1_nop", id_inst, NOP);
         end
      end

      // Decode stall: only two requests fit, head holds, then drain in order
      fires = 0; pops = 0; next_pc = 32'h0; exp_pc = 32'h0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 1'b1; req_pc = next_pc; id_ready = 1'b0;
         #1;
         if (req_valid && req_ready) begin fires++; next_pc += 4; end
         if (c >= 2) begin
            check("t2_hold_valid", id_valid, 1);
            check("t2_hold_pc", id_pc, 0);
         end
      end
      check("t2_fires", fires, 2);
      check("t2_ready_low", req_ready, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_valid = (c < 4); req_pc = next_pc; id_ready = 1'b1;
         #1;
         if (req_valid && req_ready) begin fires++; next_pc += 4; end
         if (id_valid) begin
            check("t2_pop_pc", id_pc, exp_pc);
            check("t2_pop_inst", id_inst, inst_of(exp_pc));
            exp_pc += 4; pops++;
         end
      end
      check("t2_pops", pops, 6);
      check("t2_empty", id_valid, 0);

      // Flush while a response returns; the dropped entries never appear
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h20; id_ready = 1'b0;
      #1; check("t3_ready0", req_ready, 1);
      @(negedge clk);
      req_pc = 32'h24;
      #1; check("t3_ready1", req_ready, 1);
      @(negedge clk);
      flush = 1'b1; req_pc = 32'h28;
      #1; check("t3_ready_flush", req_ready, 0);
      @(negedge clk);
      flush = 1'b0; req_pc = 32'h40; id_ready = 1'b1;
      #1;
      check("t3_valid_after", id_valid, 0);
      check("t3_nop_after", id_inst, NOP);
      check("t3_ready_after", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1; check("t3_lat", id_valid, 0);
      @(negedge clk);
      #1;
      check("t3_valid_40", id_valid, 1);
      check("t3_pc_40", id_pc, 32'h40);
      check("t3_inst_40", id_inst, inst_of(32'h40));
      @(negedge clk);
      #1; check("t3_empty", id_valid, 0);

      // Reset mid-operation with a queued entry and one in flight
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h80; id_ready = 1'b0;
      @(negedge clk);
      req_pc = 32'h84;
      @(negedge clk);
      rst_n = 1'b0;
      #1; check("t4_ready_rst", req_ready, 0);
      @(negedge clk);
      #1;
      check("t4_valid", id_valid, 0);
      check("t4_inst", id_inst, NOP);
      check("t4_pc", id_pc, 0);
      check("t4_ctrl", id_is_ctrl, 0);
      check("t4_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1; req_pc = 32'hC0; id_ready = 1'b1;
      #1;
      check("t4_rel_valid", id_valid, 0);
      check("t4_rel_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1; check("t4_lat", id_valid, 0);
      @(negedge clk);
      #1;
      check("t4_valid_c0", id_valid, 1);
      check("t4_pc_c0", id_pc, 32'hC0);
      @(negedge clk);
      #1; check("t4_empty", id_valid, 0);

      // Predecode flag: JAL then NOP
      @(negedge clk);
      req_valid = 1'b1; req_pc = 32'h400; id_ready = 1'b1;
      @(negedge clk);
      req_pc = 32'h404;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("t6_pc_jal", id_pc, 32'h400);
      check("t6_inst_jal", id_inst, 32'h0000_006F);
      check("t6_ctrl_jal", id_is_ctrl, EXP_CTRL);
      @(negedge clk);
      #1;
      check("t6_inst_nop", id_inst, 32'h0000_0013);
      check("t6_ctrl_nop", id_is_ctrl, 0);
      @(negedge clk);
      #1; check("t6_ctrl_empty", id_is_ctrl, 0);

      // DEPTH=3: hold count at DEPTH-1 with a push and pop every cycle
      next_pc = 32'h0; exp_pc = 32'h0; tail_pops = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid_3 = 1'b1; req_pc_3 = next_pc; id_ready_3 = 1'b0;
         #1;
         check("t5_fill_ready", req_ready_3, 1);
         if (req_valid_3 && req_ready_3) next_pc += 4;
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid_3 = 1'b1; req_pc_3 = next_pc; id_ready_3 = 1'b1;
         #1;
         check("t5_ready", req_ready_3, 1);
         check("t5_valid", id_valid_3, 1);
         check("t5_pc", id_pc_3, exp_pc);
         check("t5_inst", id_inst_3, inst_of(exp_pc));
         exp_pc += 4;
         if (req_valid_3 && req_ready_3) next_pc += 4;
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid_3 = 1'b0; id_ready_3 = 1'b1;
         #1;
         if (id_valid_3) begin
            check("t5_tail_pc", id_pc_3, exp_pc);
            exp_pc += 4; tail_pops++;
         end
      end
      check("t5_tail_pops", tail_pops, 3);
      check("t5_total", exp_pc, 32'd52);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
